// File: rtl/regfile_commit_sched.sv
// ROB-to-regfile commit scheduler: 2-wide in-order enqueue, 1-wide drain, 1-cycle registered output.
// Backpressure via out_rob_full; a mispredict stalls fetch and drains older commits before out_xbp fires.
module regfile_commit_sched #(
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_rob_valid0,
  input  logic [REG_W-1:0]  in_rob_reg0,
  input  logic [ROB_W-1:0]  in_rob_rob0,
  input  logic [DATA_W-1:0] in_rob_value0,
  input  logic              in_rob_valid1,
  input  logic [REG_W-1:0]  in_rob_reg1,
  input  logic [ROB_W-1:0]  in_rob_rob1,
  input  logic [DATA_W-1:0] in_rob_value1,
  input  logic              in_rob_xbp,
  output logic              out_rob_full,
  output logic [REG_W-1:0]  out_commit_reg,
  output logic [ROB_W-1:0]  out_commit_rob,
  output logic [DATA_W-1:0] out_commit_value,
  output logic              out_xbp,
  output logic              out_fetcher_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(DEPTH - 2);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] value;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nx;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           out_q, out_d;
  logic             xbp_q, xbp_d, stall_q, stall_d;

  entry_t     slot0, slot1;
  logic       enq_en, take0, take1, deq;
  logic [1:0] enq_n;

  assign slot0 = {in_rob_reg0, in_rob_rob0, in_rob_value0};
  assign slot1 = {in_rob_reg1, in_rob_rob1, in_rob_value1};

  // Full also covers DRAIN/FLUSH so the ROB stops presenting commits during a flush.
  assign out_rob_full = (count_q > FULL_THR) || (state_q != RUN);

  assign enq_en    = rdy && (state_q == RUN) && !out_rob_full;
  assign take0     = enq_en && in_rob_valid0 && (in_rob_reg0 != '0);
  assign take1     = enq_en && in_rob_valid1 && (in_rob_reg1 != '0);
  assign enq_n     = {1'b0, take0} + {1'b0, take1};
  assign deq       = rdy && (count_q != '0);
  assign wr_ptr_nx = wr_ptr_q + 1'b1;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    state_d  = state_q;
    xbp_d    = xbp_q;
    stall_d  = stall_q;

    // Slot 0 is older, so it always lands at the lower FIFO position.
    if (take0 && take1) begin
      mem_d[wr_ptr_q]  = slot0;
      mem_d[wr_ptr_nx] = slot1;
    end else if (take0) begin
      mem_d[wr_ptr_q] = slot0;
    end else if (take1) begin
      mem_d[wr_ptr_q] = slot1;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
    count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq);

    if (rdy) begin
      if (deq) begin
        out_d    = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        out_d = '0;
      end

      unique case (state_q)
        RUN:     if (in_rob_xbp) state_d = DRAIN;
        // An empty, non-popping edge means the last real commit has already been presented.
        DRAIN:   if (!deq) state_d = FLUSH;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase

      xbp_d   = (state_d == FLUSH);
      stall_d = (state_d != RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      xbp_q    <= 1'b0;
      stall_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      xbp_q    <= xbp_d;
      stall_q  <= stall_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign out_commit_reg    = out_q.rd;
  assign out_commit_rob    = out_q.rob;
  assign out_commit_value  = out_q.value;
  assign out_xbp           = xbp_q;
  assign out_fetcher_stall = stall_q;

endmodule

// File: tb/tb_regfile_commit_sched.sv
// Directed bench for regfile_commit_sched: hand-computed vectors checked with immediate assertions.
module tb_regfile_commit_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_rob_valid0, in_rob_valid1, in_rob_xbp;
  logic [4:0]  in_rob_reg0, in_rob_reg1;
  logic [3:0]  in_rob_rob0, in_rob_rob1;
  logic [31:0] in_rob_value0, in_rob_value1;
  logic        out_rob_full, out_xbp, out_fetcher_stall;
  logic [4:0]  out_commit_reg;
  logic [3:0]  out_commit_rob;
  logic [31:0] out_commit_value;

  int errors = 0;
  int checks = 0;

  regfile_commit_sched #(.REG_W(5), .ROB_W(4), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_rob_valid0(in_rob_valid0), .in_rob_reg0(in_rob_reg0),
    .in_rob_rob0(in_rob_rob0), .in_rob_value0(in_rob_value0),
    .in_rob_valid1(in_rob_valid1), .in_rob_reg1(in_rob_reg1),
    .in_rob_rob1(in_rob_rob1), .in_rob_value1(in_rob_value1),
    .in_rob_xbp(in_rob_xbp),
    .out_rob_full(out_rob_full),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value),
    .out_xbp(out_xbp), .out_fetcher_stall(out_fetcher_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commits for reg r carry rob=r[3:0] and value=0xA0000000+r, so r alone names the expected triple.
  task automatic chk_out(input string tag, input logic [4:0] r);
    logic [31:0] v;
    v = (r == 5'd0) ? 32'h0 : 32'hA000_0000 + {27'h0, r};
    chk({tag, ".reg"}, {59'h0, out_commit_reg}, {59'h0, r});
    chk({tag, ".rob"}, {60'h0, out_commit_rob}, (r == 5'd0) ? 64'h0 : {60'h0, r[3:0]});
    chk({tag, ".val"}, {32'h0, out_commit_value}, {32'h0, v});
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic v1, input logic [4:0] r1,
                       input logic xbp);
    in_rob_valid0 = v0;
    in_rob_reg0   = r0;
    in_rob_rob0   = r0[3:0];
    in_rob_value0 = 32'hA000_0000 + {27'h0, r0};
    in_rob_valid1 = v1;
    in_rob_reg1   = r1;
    in_rob_rob1   = r1[3:0];
    in_rob_value1 = 32'hA000_0000 + {27'h0, r1};
    in_rob_xbp    = xbp;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic full, input logic xbp, input logic stall);
    chk({tag, ".full"}, {63'h0, out_rob_full}, {63'h0, full});
    chk({tag, ".xbp"}, {63'h0, out_xbp}, {63'h0, xbp});
    chk({tag, ".stall"}, {63'h0, out_fetcher_stall}, {63'h0, stall});
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    #12;
    rst = 1'b0;
    chk_out("reset", 5'd0);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);

    // Single commit with explicit rob/value.
    in_rob_valid0 = 1'b1;
    in_rob_reg0   = 5'd5;
    in_rob_rob0   = 4'd3;
    in_rob_value0 = 32'hDEAD_BEEF;
    step();
    idle();
    chk("single.enq_edge.reg", {59'h0, out_commit_reg}, 64'd0);
    step();
    chk("single.reg", {59'h0, out_commit_reg}, 64'd5);
    chk("single.rob", {60'h0, out_commit_rob}, 64'd3);
    chk("single.val", {32'h0, out_commit_value}, 64'hDEAD_BEEF);
    step();
    chk_out("single.after", 5'd0);

    // Dual commit with reg-0 drop on slot 0.
    drive(1'b1, 5'd0, 1'b1, 5'd7, 1'b0);
    step();
    drive(1'b1, 5'd8, 1'b1, 5'd9, 1'b0);
    step();
    idle();
    chk_out("dual.c1", 5'd7);
    step();
    chk_out("dual.c2", 5'd8);
    step();
    chk_out("dual.c3", 5'd9);
    step();
    chk_out("dual.c4", 5'd0);

    // Backpressure: two dual commits fill to 3, valids while full are dropped.
    drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b0);
    step();
    chk("full.cnt2", {63'h0, out_rob_full}, 64'd0);
    drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b0);
    step();
    chk("full.cnt3", {63'h0, out_rob_full}, 64'd1);
    chk_out("full.o10", 5'd10);
    drive(1'b1, 5'd14, 1'b1, 5'd15, 1'b0);
    step();
    idle();
    chk("full.release", {63'h0, out_rob_full}, 64'd0);
    chk_out("full.o11", 5'd11);
    step();
    chk_out("full.o12", 5'd12);
    step();
    chk_out("full.o13", 5'd13);
    step();
    chk_out("full.dropped", 5'd0);

    // Mispredict with an empty FIFO: DRAIN, FLUSH, RUN on consecutive edges.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step();
    idle();
    chk_ctl("xbp0.e0", 1'b1, 1'b0, 1'b1);
    step();
    chk_ctl("xbp0.e1", 1'b1, 1'b1, 1'b1);
    chk_out("xbp0.e1", 5'd0);
    step();
    chk_ctl("xbp0.e2", 1'b0, 1'b0, 1'b0);

    // Mispredict with backlog 1,2,3 plus same-cycle commit 4.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    step();
    chk_out("mp.o1", 5'd1);
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
    step();
    drive(1'b1, 5'd20, 1'b1, 5'd21, 1'b1);
    chk_out("mp.o2", 5'd2);
    chk_ctl("mp.drain", 1'b1, 1'b0, 1'b1);
    step();
    chk_out("mp.o3", 5'd3);
    step();
    chk_out("mp.o4", 5'd4);
    chk("mp.o4.xbp", {63'h0, out_xbp}, 64'd0);
    step();
    idle();
    chk_out("mp.flush", 5'd0);
    chk_ctl("mp.flush", 1'b1, 1'b1, 1'b1);
    step();
    chk_ctl("mp.run", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("mp.no_stale", 5'd0);

    // rdy=0 freezes a drain in progress.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b1);
    step();
    idle();
    chk_out("rdy.o1", 5'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("rdy.hold", 5'd1);
      chk_ctl("rdy.hold", 1'b1, 1'b0, 1'b1);
    end
    rdy = 1'b1;
    step();
    chk_out("rdy.o2", 5'd2);
    step();
    chk_out("rdy.o3", 5'd3);
    step();
    chk_ctl("rdy.flush", 1'b1, 1'b1, 1'b1);
    step();
    chk_ctl("rdy.run", 1'b0, 1'b0, 1'b0);

    // Async reset mid-drain discards queued commits and suppresses the flush pulse.
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
    step();
    drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b1);
    step();
    idle();
    chk_out("rst.o5", 5'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst.async", 5'd0);
    chk_ctl("rst.async", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("rst.after", 5'd0);
      chk_ctl("rst.after", 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
